fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
Instruction fetch stage that sits directly upstream of the instruction ROM and decode. It holds the fetch PC, drives the ROM word address, and captures each 64-bit packet as two 32-bit instructions. Instructions are buffered in a small circular queue that presents up to two in-order instructions per cycle to the dual-issue decode stage. Control-flow redirects flush the queue.

Parameters:
DATA_WIDTH, 64, ROM word width; exactly two 32-bit instructions per word.
ADDR_WIDTH, 10, ROM word-address width.
DEPTH, 8, queue entries (one instruction each); power of 2, at least 4.
RESET_PC, 32'h0000_0000, fetch byte address after reset.

Ports:
clk  in  1  clock; all state updates on the rising edge.
srst_n  in  1  reset; asynchronous, active-low.
rom_addr  out  ADDR_WIDTH  ROM word address, equal to fetch_pc[ADDR_WIDTH+2:3].
rom_rdata  in  DATA_WIDTH  ROM data, valid combinationally for rom_addr in the same cycle. Bits [31:0] are at pc+0; bits [63:32] are at pc+4.
redirect_valid  in  1  flush the queue and restart fetch.
redirect_pc  in  32  new fetch byte address; bits [1:0] are ignored and treated as 0.
inst0_valid  out  1  head entry valid.
inst0  out  32  head instruction.
inst0_pc  out  32  head PC.
inst1_valid  out  1  second entry valid.
inst1  out  32  second instruction.
inst1_pc  out  32  second PC.
issue_cnt  in  2  instructions consumed this cycle (0, 1 or 2); must not exceed the number of valid outputs.

Behaviour:
- State:
  - fetch_pc, 32 bits.
  - rd_ptr and wr_ptr, log2(DEPTH) bits each; both wrap modulo DEPTH.
  - count, log2(DEPTH)+1 bits.
  - Per entry: inst and pc, 32 bits each.
- Reset (asynchronous, srst_n=0):
  - fetch_pc=RESET_PC; pointers=0; count=0.
  - inst0_valid=0 and inst1_valid=0; all other outputs read 0.
- Outputs are combinational from the queue head:
  - inst0_valid = (count>=1); inst1_valid = (count>=2).
  - inst0/inst0_pc come from entry rd_ptr; inst1/inst1_pc come from entry rd_ptr+1 mod DEPTH.
  - When an output is not valid, its data is don't-care.
- Push slots: nslot = 1 if fetch_pc[2]=1, otherwise 2.
  - With fetch_pc[2]=1, only the high half (pc = fetch_pc) is written.
  - Otherwise the low half is written at pc = fetch_pc, then the high half at pc = fetch_pc+4.
- Push condition: redirect_valid=0 AND (DEPTH - count + issue_cnt) >= nslot.
  - Space freed by this cycle's pops is usable in the same cycle.
  - On push: wr_ptr += nslot, and fetch_pc = {fetch_pc[31:3]+1, 3'b000}.
  - On no push: fetch_pc holds and rom_addr is unchanged.
- Pop: rd_ptr += issue_cnt each cycle that redirect_valid=0.
- Count update: count_next = count - issue_cnt + (push ? nslot : 0).
- Simultaneous push and pop in one cycle is legal; full occupancy (count=DEPTH) is legal.
- Redirect (redirect_valid=1):
  - Next edge: count=0, rd_ptr=wr_ptr=0, fetch_pc={redirect_pc[31:2],2'b00}.
  - issue_cnt and rom_rdata are ignored this cycle.
  - The cycle after the redirect shows inst0_valid=0; the first redirected instruction is valid the cycle after that.
  - Redirect has priority over push and pop.
- Latency: the ROM word at fetch_pc is visible on inst0 one cycle after the edge that pushes it (the first instruction after reset is valid on cycle 1).
- Address wrap: fetch_pc is 32-bit modular. rom_addr truncates, so fetch wraps to ROM word 0 at 8*2^ADDR_WIDTH bytes.
- issue_cnt greater than the valid count is illegal. It is caught by an assertion in simulation; hardware behaviour is undefined.

Optional Feature:
FETCH_QUEUE_PERF_EN
- Defined:
  - Adds output fq_bubble_cnt [31:0], reset to 0.
  - Increments by 1 each cycle with inst0_valid=0 and redirect_valid=0; saturates at 32'hFFFF_FFFF.
  - It is not cleared by redirect.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset with RESET_PC=0, ROM[0]=64'hBBBB_BBBB_AAAA_AAAA, issue_cnt=0:
  - Cycle 1: inst0=AAAA_AAAA at pc 0; inst1=BBBB_BBBB at pc 4.
  - After 4 pushes count=8 and rom_addr holds at 4.
- Steady state with issue_cnt=2 every cycle:
  - The PCs 0,4,8,C… are issued with no gaps.
  - rom_addr increments by 1 each cycle; count stays at 2 after warm-up.
- Queue full (count=8) with issue_cnt=1:
  - No push (free=1 < 2); count becomes 7.
  - The next cycle with issue_cnt=1 pushes 2; count becomes 8.
- Redirect with redirect_pc=32'h0000_0014 (fetch_pc[2]=1):
  - Next cycle: inst0_valid=0 and rom_addr=2.
  - Following cycle: only ROM[2][63:32] at pc 0x14 (count=1), then ROM[3] at pc 0x18/0x1C.
- redirect_valid and issue_cnt=2 in the same cycle with count=6:
  - Count becomes 0 and no pop is applied.
  - Pointers restart at 0; the redirected stream is correct.
- Assert srst_n=0 asynchronously mid-stream (between edges):
  - inst0_valid=0 immediately.
  - After release, fetch restarts at RESET_PC.
  - With FETCH_QUEUE_PERF_EN defined, fq_bubble_cnt=0.

Source files
------------

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Instruction fetch front end between the instruction ROM and a dual-issue
// decoder. Holds the fetch PC, addresses the ROM one 64-bit word at a time,
// splits each word into two 32-bit instructions and buffers them in a small
// circular queue. The two oldest instructions are presented to decode every
// cycle. A redirect flushes the queue and restarts fetch at a new PC.
//
// Ports:
//   clk             clock, all state changes on the rising edge
//   srst_n          asynchronous active-low reset
//   rom_addr        ROM word address (fetch_pc[ADDR_WIDTH+2:3])
//   rom_rdata       ROM word for rom_addr, same cycle; [31:0] at pc+0, [63:32] at pc+4
//   redirect_valid  flush queue and restart fetch at redirect_pc
//   redirect_pc     new fetch byte address, bits [1:0] ignored
//   inst0_valid/inst0/inst0_pc   head instruction
//   inst1_valid/inst1/inst1_pc   second instruction
//   issue_cnt       instructions consumed by decode this cycle (0..2)
//   fq_bubble_cnt   (only with FETCH_QUEUE_PERF_EN) saturating count of cycles
//                   with no head instruction and no redirect
//
// Build option: define FETCH_QUEUE_PERF_EN to add the bubble counter.
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DEPTH      = 8,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  srst_n,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_rdata,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  inst0_valid,
    output logic [31:0]           inst0,
    output logic [31:0]           inst0_pc,
    output logic                  inst1_valid,
    output logic [31:0]           inst1,
    output logic [31:0]           inst1_pc,
    input  logic [1:0]            issue_cnt
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [31:0]           fq_bubble_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [31:0]      inst_q [DEPTH];
    logic [31:0]      pc_q   [DEPTH];

    logic [1:0]       nslot;
    logic [CNT_W:0]   free_slots;
    logic             push;
    logic [PTR_W-1:0] rd_ptr_p1;
    logic [PTR_W-1:0] wr_ptr_p1;
    logic             unused_redirect_lsbs;

    // Redirect targets are word aligned; the low two bits carry no information.
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign rom_addr  = fetch_pc_q[ADDR_WIDTH+2:3];
    assign rd_ptr_p1 = rd_ptr_q + PTR_W'(1);
    assign wr_ptr_p1 = wr_ptr_q + PTR_W'(1);

    // A PC in the upper half of a ROM word only contributes that upper half.
    assign nslot = fetch_pc_q[2] ? 2'd1 : 2'd2;

    // Slots freed by this cycle's pops are reusable by this cycle's push,
    // which keeps a full queue streaming at two instructions per cycle.
    assign free_slots = (CNT_W+1)'(DEPTH) - {1'b0, count_q} + (CNT_W+1)'(issue_cnt);
    assign push       = !redirect_valid && (free_slots >= (CNT_W+1)'(nslot));

    assign inst0_valid = (count_q != '0);
    assign inst1_valid = (count_q >= CNT_W'(2));

    // Invalid outputs are forced to zero so reset state reads as all zeros.
    assign inst0    = inst0_valid ? inst_q[rd_ptr_q]  : '0;
    assign inst0_pc = inst0_valid ? pc_q[rd_ptr_q]    : '0;
    assign inst1    = inst1_valid ? inst_q[rd_ptr_p1] : '0;
    assign inst1_pc = inst1_valid ? pc_q[rd_ptr_p1]   : '0;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (redirect_valid) begin
            // Redirect wins over push and pop; the queue restarts empty.
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(issue_cnt);
            count_d  = count_q - CNT_W'(issue_cnt) + (push ? CNT_W'(nslot) : '0);
            if (push) begin
                wr_ptr_d   = wr_ptr_q + PTR_W'(nslot);
                fetch_pc_d = {fetch_pc_q[31:3] + 29'd1, 3'b000};
            end
        end
    end

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Queue storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            if (fetch_pc_q[2]) begin
                inst_q[wr_ptr_q] <= rom_rdata[63:32];
                pc_q[wr_ptr_q]   <= fetch_pc_q;
            end else begin
                inst_q[wr_ptr_q]  <= rom_rdata[31:0];
                pc_q[wr_ptr_q]    <= fetch_pc_q;
                inst_q[wr_ptr_p1] <= rom_rdata[63:32];
                pc_q[wr_ptr_p1]   <= fetch_pc_q | 32'd4;
            end
        end
    end

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (!inst0_valid && !redirect_valid && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign fq_bubble_cnt = bubble_cnt_q;
`endif

`ifndef SYNTHESIS
    logic [1:0] valid_out_cnt;
    assign valid_out_cnt = inst1_valid ? 2'd2 : (inst0_valid ? 2'd1 : 2'd0);

    // Decode may never consume more instructions than are presented.
    issue_within_valid_a: assert property (
        @(posedge clk) disable iff (!srst_n)
        !redirect_valid |-> (issue_cnt <= valid_out_cnt)
    );
`endif

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    logic        clk;
    logic        srst_n;
    logic [9:0]  rom_addr;
    logic [63:0] rom_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst0_valid;
    logic [31:0] inst0;
    logic [31:0] inst0_pc;
    logic        inst1_valid;
    logic [31:0] inst1;
    logic [31:0] inst1_pc;
    logic [1:0]  issue_cnt;
`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] fq_bubble_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    fetch_queue dut (
        .clk            (clk),
        .srst_n         (srst_n),
        .rom_addr       (rom_addr),
        .rom_rdata      (rom_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst0_valid    (inst0_valid),
        .inst0          (inst0),
        .inst0_pc       (inst0_pc),
        .inst1_valid    (inst1_valid),
        .inst1          (inst1),
        .inst1_pc       (inst1_pc),
        .issue_cnt      (issue_cnt)
`ifdef FETCH_QUEUE_PERF_EN
        ,
        .fq_bubble_cnt  (fq_bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: word 0 is the fixed pattern, other words encode their own address.
    function automatic logic [63:0] rom_word(input logic [9:0] w);
        logic [31:0] lo;
        logic [31:0] hi;
        if (w == 10'd0) return 64'hBBBB_BBBB_AAAA_AAAA;
        lo = 32'h3C00_0000 ^ {19'd0, w, 3'b000};
        hi = 32'h5A00_0000 ^ {19'd0, w, 3'b100};
        return {hi, lo};
    endfunction

    function automatic logic [31:0] inst_at(input logic [31:0] pc);
        logic [63:0] word;
        word = rom_word(pc[12:3]);
        return pc[2] ? word[63:32] : word[31:0];
    endfunction

    assign rom_rdata = rom_word(rom_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard of the in-order PC stream decode should see.
    logic [31:0] exp_q[$];
    logic [31:0] next_pc;

    task automatic sb_fill();
        while (exp_q.size() < 16) begin
            exp_q.push_back(next_pc);
            next_pc = next_pc + 32'd4;
        end
    endtask

    task automatic sb_restart(input logic [31:0] pc);
        exp_q.delete();
        next_pc = {pc[31:2], 2'b00};
        sb_fill();
    endtask

    task automatic sb_issue(input int n, input string tag);
        logic [31:0] e;
        for (int k = 0; k < n; k++) begin
            e = exp_q.pop_front();
            if (k == 0) begin
                chk({tag, " inst0_pc"}, inst0_pc, e);
                chk({tag, " inst0"}, inst0, inst_at(e));
            end else begin
                chk({tag, " inst1_pc"}, inst1_pc, e);
                chk({tag, " inst1"}, inst1, inst_at(e));
            end
        end
        sb_fill();
    endtask

    typedef struct {
        logic [1:0]  issue;
        logic        redir;
        logic [31:0] rpc;
        logic        v0;
        logic        v1;
        logic [31:0] pc0;
        logic [31:0] pc1;
        logic [9:0]  addr;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input logic [1:0] is, input logic rd, input logic [31:0] rpc,
                                input logic v0, input logic v1, input logic [31:0] p0,
                                input logic [31:0] p1, input logic [9:0] a);
        vec_t v;
        v.issue = is; v.redir = rd; v.rpc = rpc;
        v.v0 = v0; v.v1 = v1; v.pc0 = p0; v.pc1 = p1; v.addr = a;
        return v;
    endfunction

    initial begin
        int avail;
        int n;
        logic [31:0] rpc;

        // Each row: inputs for one edge, then expected outputs after it.
        vecs[0]  = mk(2'd0, 1'b0, 32'h0,    1, 1, 32'h0,    32'h4,    10'd1);
        vecs[1]  = mk(2'd0, 1'b0, 32'h0,    1, 1, 32'h0,    32'h4,    10'd2);
        vecs[2]  = mk(2'd0, 1'b0, 32'h0,    1, 1, 32'h0,    32'h4,    10'd3);
        vecs[3]  = mk(2'd0, 1'b0, 32'h0,    1, 1, 32'h0,    32'h4,    10'd4);
        vecs[4]  = mk(2'd0, 1'b0, 32'h0,    1, 1, 32'h0,    32'h4,    10'd4);
        vecs[5]  = mk(2'd1, 1'b0, 32'h0,    1, 1, 32'h4,    32'h8,    10'd4);
        vecs[6]  = mk(2'd1, 1'b0, 32'h0,    1, 1, 32'h8,    32'hC,    10'd5);
        vecs[7]  = mk(2'd2, 1'b0, 32'h0,    1, 1, 32'h10,   32'h14,   10'd6);
        vecs[8]  = mk(2'd2, 1'b0, 32'h0,    1, 1, 32'h18,   32'h1C,   10'd7);
        vecs[9]  = mk(2'd2, 1'b1, 32'h14,   0, 0, 32'h0,    32'h0,    10'd2);
        vecs[10] = mk(2'd0, 1'b0, 32'h0,    1, 0, 32'h14,   32'h0,    10'd3);
        vecs[11] = mk(2'd0, 1'b0, 32'h0,    1, 1, 32'h14,   32'h18,   10'd4);
        vecs[12] = mk(2'd1, 1'b0, 32'h0,    1, 1, 32'h18,   32'h1C,   10'd5);
        vecs[13] = mk(2'd2, 1'b0, 32'h0,    1, 1, 32'h20,   32'h24,   10'd6);
        vecs[14] = mk(2'd0, 1'b0, 32'h0,    1, 1, 32'h20,   32'h24,   10'd7);
        vecs[15] = mk(2'd2, 1'b1, 32'h43,   0, 0, 32'h0,    32'h0,    10'd8);
        vecs[16] = mk(2'd0, 1'b0, 32'h0,    1, 1, 32'h40,   32'h44,   10'd9);
        vecs[17] = mk(2'd0, 1'b1, 32'h1FFC, 0, 0, 32'h0,    32'h0,    10'd1023);
        vecs[18] = mk(2'd0, 1'b0, 32'h0,    1, 0, 32'h1FFC, 32'h0,    10'd0);
        vecs[19] = mk(2'd0, 1'b0, 32'h0,    1, 1, 32'h1FFC, 32'h2000, 10'd1);

        srst_n         = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        issue_cnt      = 2'd0;
        step();
        step();

        chk("rst inst0_valid", 32'(inst0_valid), 32'd0);
        chk("rst inst1_valid", 32'(inst1_valid), 32'd0);
        chk("rst inst0", inst0, 32'h0);
        chk("rst inst0_pc", inst0_pc, 32'h0);
        chk("rst inst1", inst1, 32'h0);
        chk("rst inst1_pc", inst1_pc, 32'h0);
        chk("rst rom_addr", 32'(rom_addr), 32'd0);
`ifdef FETCH_QUEUE_PERF_EN
        chk("rst bubble", fq_bubble_cnt, 32'd0);
`endif
        srst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            issue_cnt      = vecs[i].issue;
            redirect_valid = vecs[i].redir;
            redirect_pc    = vecs[i].rpc;
            step();
            chk($sformatf("vec%0d inst0_valid", i), 32'(inst0_valid), 32'(vecs[i].v0));
            chk($sformatf("vec%0d inst1_valid", i), 32'(inst1_valid), 32'(vecs[i].v1));
            chk($sformatf("vec%0d rom_addr", i), 32'(rom_addr), 32'(vecs[i].addr));
            if (vecs[i].v0) begin
                chk($sformatf("vec%0d inst0_pc", i), inst0_pc, vecs[i].pc0);
                chk($sformatf("vec%0d inst0", i), inst0, inst_at(vecs[i].pc0));
            end
            if (vecs[i].v1) begin
                chk($sformatf("vec%0d inst1_pc", i), inst1_pc, vecs[i].pc1);
                chk($sformatf("vec%0d inst1", i), inst1, inst_at(vecs[i].pc1));
            end
            if (i == 0) begin
                chk("first inst0", inst0, 32'hAAAA_AAAA);
                chk("first inst1", inst1, 32'hBBBB_BBBB);
            end
        end
        issue_cnt      = 2'd0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Asynchronous reset between clock edges while the queue holds data.
        chk("pre-reset inst0_valid", 32'(inst0_valid), 32'd1);
        #2;
        srst_n = 1'b0;
        #1;
        chk("async rst inst0_valid", 32'(inst0_valid), 32'd0);
        chk("async rst inst1_valid", 32'(inst1_valid), 32'd0);
        chk("async rst rom_addr", 32'(rom_addr), 32'd0);
`ifdef FETCH_QUEUE_PERF_EN
        chk("async rst bubble", fq_bubble_cnt, 32'd0);
`endif
        #2;
        srst_n = 1'b1;
        sb_restart(32'h0);
        step();
`ifdef FETCH_QUEUE_PERF_EN
        chk("bubble after first cycle", fq_bubble_cnt, 32'd1);
`endif

        // Steady state: two instructions per cycle with no gaps.
        for (int c = 1; c <= 20; c++) begin
            chk($sformatf("steady%0d inst0_valid", c), 32'(inst0_valid), 32'd1);
            chk($sformatf("steady%0d inst1_valid", c), 32'(inst1_valid), 32'd1);
            chk($sformatf("steady%0d rom_addr", c), 32'(rom_addr), 32'(c));
            sb_issue(2, $sformatf("steady%0d", c));
            issue_cnt = 2'd2;
            step();
        end
`ifdef FETCH_QUEUE_PERF_EN
        chk("bubble steady", fq_bubble_cnt, 32'd1);
`endif

        // Random issue widths with occasional redirects.
        for (int c = 0; c < 400; c++) begin
            avail = inst1_valid ? 2 : (inst0_valid ? 1 : 0);
            n     = $urandom_range(avail, 0);
            if ($urandom_range(15, 0) == 0) begin
                rpc            = $urandom;
                redirect_valid = 1'b1;
                redirect_pc    = rpc;
                issue_cnt      = 2'(n);
                sb_restart(rpc);
                step();
                chk($sformatf("rnd%0d redirect inst0_valid", c), 32'(inst0_valid), 32'd0);
                chk($sformatf("rnd%0d redirect rom_addr", c), 32'(rom_addr), 32'(rpc[12:3]));
                redirect_valid = 1'b0;
            end else begin
                sb_issue(n, $sformatf("rnd%0d", c));
                issue_cnt = 2'(n);
                step();
            end
        end
        issue_cnt = 2'd0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
